cam_clk_sequencer: RTL and testbench

- Power-up and clock supervisor for the OV7670 camera front end, running in the 50 MHz system domain.
- Pulses the 24 MHz DCM reset and waits for DCM lock, retrying on timeout.
- Once the clock is stable: enables XCLK, then drives the camera PWDN and RESET pins in the required order.
- Flags cam_ready so the SCCB configuration logic may start; re-runs the whole sequence on lock loss or on a soft restart.

---
 rtl/cam_seq_pkg.sv | 43 ++++
 rtl/cam_clk_sequencer_sync.sv | 31 +++
 rtl/cam_clk_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_cam_clk_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_seq_pkg.sv
// Shared definitions for the OV7670 camera clock/power sequencer.
//   state_t      : FSM state encoding (0..7), also exported on state_dbg
//   DEF_*        : default timing constants in 50 MHz clk_in cycles
//   clog2/max_of : helpers for sizing the shared sequencing timer
package cam_seq_pkg;

    typedef enum logic [2:0] {
        S_DCM_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_PWDN      = 3'd3,
        S_RST_LOW   = 3'd4,
        S_POST_RST  = 3'd5,
        S_READY     = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    localparam int DEF_DCM_RST_CYCLES  = 4;
    localparam int DEF_LOCK_TIMEOUT    = 50000;
    localparam int DEF_LOCK_STABLE     = 1024;
    localparam int DEF_PWDN_CYCLES     = 50000;
    localparam int DEF_RST_LOW_CYCLES  = 50000;
    localparam int DEF_POST_RST_CYCLES = 50000;
    localparam int DEF_MAX_RETRY       = 3;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_clk_sequencer_sync.sv
// sync_2ff: generic two-flop synchroniser for slow level signals crossing
// into the local clock domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (outputs clear to 0)
//   d     : asynchronous input(s)
//   q     : synchronised output(s), two clk cycles of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/cam_clk_sequencer.sv
// cam_clk_sequencer: power-up and clock supervisor for the OV7670 front end.
// Pulses the DCM reset, waits for a stable lock (retrying on timeout), then
// enables XCLK and walks the camera PWDN / RESET pins before flagging ready.
//   clk_in, rst_n         : 50 MHz clock, asynchronous active-low reset
//   dcm_locked            : DCM LOCKED, asynchronous, synchronised internally
//   restart               : single-cycle soft re-init request
//   dcm_rst, xclk_en      : DCM reset and XCLK gating
//   cam_pwdn, cam_reset_n : camera power-down and reset pins
//   cam_ready, seq_err    : sequence complete / lock never achieved
//   retry_cnt, state_dbg  : timeouts in this run, current state encoding
module cam_clk_sequencer
    import cam_seq_pkg::*;
#(
    parameter int DCM_RST_CYCLES  = DEF_DCM_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE     = DEF_LOCK_STABLE,
    parameter int PWDN_CYCLES     = DEF_PWDN_CYCLES,
    parameter int RST_LOW_CYCLES  = DEF_RST_LOW_CYCLES,
    parameter int POST_RST_CYCLES = DEF_POST_RST_CYCLES,
    parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       dcm_locked,
    input  logic       restart,
    output logic       dcm_rst,
    output logic       xclk_en,
    output logic       cam_pwdn,
    output logic       cam_reset_n,
    output logic       cam_ready,
    output logic       seq_err,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam int MAX_CYC = max_of(max_of(max_of(DCM_RST_CYCLES, LOCK_TIMEOUT),
                                           max_of(LOCK_STABLE, PWDN_CYCLES)),
                                    max_of(RST_LOW_CYCLES, POST_RST_CYCLES));
    localparam int TIMER_W = clog2(MAX_CYC);

    localparam logic [TIMER_W-1:0] DCM_RST_LAST  = TIMER_W'(DCM_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST   = TIMER_W'(LOCK_STABLE - 1);
    localparam logic [TIMER_W-1:0] PWDN_LAST     = TIMER_W'(PWDN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RST_LOW_LAST  = TIMER_W'(RST_LOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] POST_RST_LAST = TIMER_W'(POST_RST_CYCLES - 1);
    localparam logic [1:0]         RETRY_LIMIT   = 2'(MAX_RETRY);

    logic               locked_s;
    state_t             state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [1:0]         retry_reg, retry_next;

    logic dcm_rst_reg, dcm_rst_next;
    logic xclk_en_reg, xclk_en_next;
    logic cam_pwdn_reg, cam_pwdn_next;
    logic cam_reset_n_reg, cam_reset_n_next;
    logic cam_ready_reg, cam_ready_next;
    logic seq_err_reg, seq_err_next;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk_in),
        .rst_n (rst_n),
        .d     (dcm_locked),
        .q     (locked_s)
    );

    // Next-state, retry counter and timer.
    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        if (restart) begin
            state_next = S_DCM_RST;
            retry_next = 2'd0;
        end else begin
            case (state_reg)
                S_DCM_RST: begin
                    if (timer_reg == DCM_RST_LAST) state_next = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // Lock is checked before the timeout: a lock that arrives
                    // on the final timeout cycle is accepted, not retried.
                    if (locked_s) begin
                        state_next = S_STABLE;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        if (retry_reg < RETRY_LIMIT) begin
                            retry_next = retry_reg + 2'd1;
                            state_next = S_DCM_RST;
                        end else begin
                            state_next = S_ERROR;
                        end
                    end
                end
                S_STABLE: begin
                    // A dropout here only restarts the stability window.
                    if (!locked_s)                  state_next = S_WAIT_LOCK;
                    else if (timer_reg == STABLE_LAST) state_next = S_PWDN;
                end
                S_PWDN: begin
                    if (!locked_s)                 state_next = S_DCM_RST;
                    else if (timer_reg == PWDN_LAST) state_next = S_RST_LOW;
                end
                S_RST_LOW: begin
                    if (!locked_s)                    state_next = S_DCM_RST;
                    else if (timer_reg == RST_LOW_LAST) state_next = S_POST_RST;
                end
                S_POST_RST: begin
                    if (!locked_s) begin
                        state_next = S_DCM_RST;
                    end else if (timer_reg == POST_RST_LAST) begin
                        state_next = S_READY;
                        retry_next = 2'd0;
                    end
                end
                S_READY: begin
                    if (!locked_s) state_next = S_DCM_RST;
                end
                default: begin
                    state_next = S_ERROR;
                end
            endcase
        end

        // Shared timer: cleared on any transition, idle in the terminal
        // states so it can never wrap.
        timer_next = timer_reg;
        if (restart || (state_next != state_reg)) begin
            timer_next = '0;
        end else if ((state_reg != S_READY) && (state_reg != S_ERROR)) begin
            timer_next = timer_reg + 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registered pins change
    // on the same edge as the state register.
    always_comb begin
        dcm_rst_next     = 1'b1;
        xclk_en_next     = 1'b0;
        cam_pwdn_next    = 1'b1;
        cam_reset_n_next = 1'b0;
        cam_ready_next   = 1'b0;
        seq_err_next     = 1'b0;
        case (state_next)
            S_WAIT_LOCK, S_STABLE: begin
                dcm_rst_next = 1'b0;
            end
            S_PWDN: begin
                dcm_rst_next = 1'b0;
                xclk_en_next = 1'b1;
            end
            S_RST_LOW: begin
                dcm_rst_next  = 1'b0;
                xclk_en_next  = 1'b1;
                cam_pwdn_next = 1'b0;
            end
            S_POST_RST: begin
                dcm_rst_next     = 1'b0;
                xclk_en_next     = 1'b1;
                cam_pwdn_next    = 1'b0;
                cam_reset_n_next = 1'b1;
            end
            S_READY: begin
                dcm_rst_next     = 1'b0;
                xclk_en_next     = 1'b1;
                cam_pwdn_next    = 1'b0;
                cam_reset_n_next = 1'b1;
                cam_ready_next   = 1'b1;
            end
            S_ERROR: begin
                seq_err_next = 1'b1;
            end
            default: begin
                dcm_rst_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_DCM_RST;
            timer_reg       <= '0;
            retry_reg       <= 2'd0;
            dcm_rst_reg     <= 1'b1;
            xclk_en_reg     <= 1'b0;
            cam_pwdn_reg    <= 1'b1;
            cam_reset_n_reg <= 1'b0;
            cam_ready_reg   <= 1'b0;
            seq_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            retry_reg       <= retry_next;
            dcm_rst_reg     <= dcm_rst_next;
            xclk_en_reg     <= xclk_en_next;
            cam_pwdn_reg    <= cam_pwdn_next;
            cam_reset_n_reg <= cam_reset_n_next;
            cam_ready_reg   <= cam_ready_next;
            seq_err_reg     <= seq_err_next;
        end
    end

    assign dcm_rst     = dcm_rst_reg;
    assign xclk_en     = xclk_en_reg;
    assign cam_pwdn    = cam_pwdn_reg;
    assign cam_reset_n = cam_reset_n_reg;
    assign cam_ready   = cam_ready_reg;
    assign seq_err     = seq_err_reg;
    assign retry_cnt   = retry_reg;
    assign state_dbg   = state_reg;

endmodule

// File: tb/tb_cam_clk_sequencer.sv
// Directed bench for cam_clk_sequencer with short timing parameters.
// outs packs {dcm_rst, xclk_en, cam_pwdn, cam_reset_n, cam_ready, seq_err}.
module tb_cam_clk_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       dcm_locked;
    logic       restart;
    logic       dcm_rst, xclk_en, cam_pwdn, cam_reset_n, cam_ready, seq_err;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;
    logic [5:0] outs;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected output patterns per state
    localparam logic [5:0] O_DCM   = 6'b101000;
    localparam logic [5:0] O_WAIT  = 6'b001000;
    localparam logic [5:0] O_PWDN  = 6'b011000;
    localparam logic [5:0] O_RLOW  = 6'b010000;
    localparam logic [5:0] O_POST  = 6'b010100;
    localparam logic [5:0] O_READY = 6'b010110;
    localparam logic [5:0] O_ERR   = 6'b101001;

    assign outs = {dcm_rst, xclk_en, cam_pwdn, cam_reset_n, cam_ready, seq_err};

    always #5 clk_in = ~clk_in;

    cam_clk_sequencer #(
        .DCM_RST_CYCLES  (4),
        .LOCK_TIMEOUT    (20),
        .LOCK_STABLE     (8),
        .PWDN_CYCLES     (10),
        .RST_LOW_CYCLES  (10),
        .POST_RST_CYCLES (10),
        .MAX_RETRY       (3)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .dcm_locked  (dcm_locked),
        .restart     (restart),
        .dcm_rst     (dcm_rst),
        .xclk_en     (xclk_en),
        .cam_pwdn    (cam_pwdn),
        .cam_reset_n (cam_reset_n),
        .cam_ready   (cam_ready),
        .seq_err     (seq_err),
        .retry_cnt   (retry_cnt),
        .state_dbg   (state_dbg)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (outs !== O_DCM) begin tests_failed++; $display("FAIL reset_async_outs: got %b want %b", outs, O_DCM); end
        tests_run++; if (state_dbg !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        tests_run++; if (retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
        step(2);
        rst_n = 1'b1;
        step(3);
        tests_run++; if (outs !== O_DCM) begin tests_failed++; $display("FAIL reset_dcm_pulse_hold: got %b want %b", outs, O_DCM); end
        step(1);
        tests_run++; if (state_dbg !== 3'd1 || outs !== O_WAIT) begin tests_failed++; $display("FAIL reset_dcm_pulse_end: state %0d outs %b want 1 %b", state_dbg, outs, O_WAIT); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_nominal();
        step(6);
        dcm_locked = 1'b1;
        step(10);
        tests_run++; if (state_dbg !== 3'd2 || outs !== O_WAIT) begin tests_failed++; $display("FAIL nom_stable: state %0d outs %b want 2 %b", state_dbg, outs, O_WAIT); end
        step(1);
        tests_run++; if (state_dbg !== 3'd3 || outs !== O_PWDN) begin tests_failed++; $display("FAIL nom_xclk_on: state %0d outs %b want 3 %b", state_dbg, outs, O_PWDN); end
        step(9);
        tests_run++; if (outs !== O_PWDN) begin tests_failed++; $display("FAIL nom_pwdn_hold: got %b want %b", outs, O_PWDN); end
        step(1);
        tests_run++; if (state_dbg !== 3'd4 || outs !== O_RLOW) begin tests_failed++; $display("FAIL nom_pwdn_fall: state %0d outs %b want 4 %b", state_dbg, outs, O_RLOW); end
        step(9);
        tests_run++; if (outs !== O_RLOW) begin tests_failed++; $display("FAIL nom_rstlow_hold: got %b want %b", outs, O_RLOW); end
        step(1);
        tests_run++; if (state_dbg !== 3'd5 || outs !== O_POST) begin tests_failed++; $display("FAIL nom_reset_rise: state %0d outs %b want 5 %b", state_dbg, outs, O_POST); end
        step(9);
        tests_run++; if (outs !== O_POST) begin tests_failed++; $display("FAIL nom_post_hold: got %b want %b", outs, O_POST); end
        step(1);
        tests_run++; if (state_dbg !== 3'd6 || outs !== O_READY || retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL nom_ready: state %0d outs %b retry %0d want 6 %b 0", state_dbg, outs, retry_cnt, O_READY); end
        $display("[TB] test_nominal done");
    endtask

    task automatic test_lock_loss_ready();
        dcm_locked = 1'b0;
        step(2);
        tests_run++; if (outs !== O_READY) begin tests_failed++; $display("FAIL loss_sync_delay: got %b want %b", outs, O_READY); end
        step(1);
        tests_run++; if (state_dbg !== 3'd0 || outs !== O_DCM) begin tests_failed++; $display("FAIL loss_drop: state %0d outs %b want 0 %b", state_dbg, outs, O_DCM); end
        step(3);
        tests_run++; if (outs !== O_DCM) begin tests_failed++; $display("FAIL loss_dcm_hold: got %b want %b", outs, O_DCM); end
        step(1);
        tests_run++; if (state_dbg !== 3'd1 || outs !== O_WAIT) begin tests_failed++; $display("FAIL loss_dcm_end: state %0d outs %b want 1 %b", state_dbg, outs, O_WAIT); end
        dcm_locked = 1'b1;
        step(40);
        tests_run++; if (state_dbg !== 3'd5) begin tests_failed++; $display("FAIL loss_rerun_post: got %0d want 5", state_dbg); end
        step(1);
        tests_run++; if (outs !== O_READY || retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL loss_rerun_ready: outs %b retry %0d want %b 0", outs, retry_cnt, O_READY); end
        $display("[TB] test_lock_loss_ready done");
    endtask

    task automatic test_timeout_retry();
        restart    = 1'b1;
        dcm_locked = 1'b0;
        step(1);
        restart = 1'b0;
        tests_run++; if (state_dbg !== 3'd0 || retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL retry_restart: state %0d retry %0d want 0 0", state_dbg, retry_cnt); end
        step(4);
        step(19);
        tests_run++; if (state_dbg !== 3'd1 || dcm_rst !== 1'b0) begin tests_failed++; $display("FAIL retry_wait_last: state %0d dcm_rst %b want 1 0", state_dbg, dcm_rst); end
        step(1);
        tests_run++; if (outs !== O_DCM || retry_cnt !== 2'd1) begin tests_failed++; $display("FAIL retry_first: outs %b retry %0d want %b 1", outs, retry_cnt, O_DCM); end
        step(3);
        tests_run++; if (dcm_rst !== 1'b1) begin tests_failed++; $display("FAIL retry_first_hold: got %b want 1", dcm_rst); end
        step(1);
        tests_run++; if (dcm_rst !== 1'b0) begin tests_failed++; $display("FAIL retry_first_end: got %b want 0", dcm_rst); end
        step(20);
        tests_run++; if (dcm_rst !== 1'b1 || retry_cnt !== 2'd2) begin tests_failed++; $display("FAIL retry_second: dcm_rst %b retry %0d want 1 2", dcm_rst, retry_cnt); end
        step(4);
        dcm_locked = 1'b1;
        step(40);
        tests_run++; if (state_dbg !== 3'd5 || retry_cnt !== 2'd2) begin tests_failed++; $display("FAIL retry_keep: state %0d retry %0d want 5 2", state_dbg, retry_cnt); end
        step(1);
        tests_run++; if (cam_ready !== 1'b1 || retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL retry_clear: ready %b retry %0d want 1 0", cam_ready, retry_cnt); end
        $display("[TB] test_timeout_retry done");
    endtask

    task automatic test_lock_glitch();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(5);
        tests_run++; if (state_dbg !== 3'd2) begin tests_failed++; $display("FAIL glitch_stable_entry: got %0d want 2", state_dbg); end
        step(5);
        dcm_locked = 1'b0;
        step(1);
        dcm_locked = 1'b1;
        step(2);
        tests_run++; if (state_dbg !== 3'd1 || retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL glitch_back_wait: state %0d retry %0d want 1 0", state_dbg, retry_cnt); end
        step(1);
        tests_run++; if (state_dbg !== 3'd2) begin tests_failed++; $display("FAIL glitch_restable: got %0d want 2", state_dbg); end
        step(7);
        tests_run++; if (state_dbg !== 3'd2 || outs !== O_WAIT) begin tests_failed++; $display("FAIL glitch_window: state %0d outs %b want 2 %b", state_dbg, outs, O_WAIT); end
        step(1);
        tests_run++; if (state_dbg !== 3'd3 || outs !== O_PWDN) begin tests_failed++; $display("FAIL glitch_pwdn: state %0d outs %b want 3 %b", state_dbg, outs, O_PWDN); end
        $display("[TB] test_lock_glitch done");
    endtask

    task automatic test_async_reset();
        step(15);
        tests_run++; if (state_dbg !== 3'd4 || outs !== O_RLOW) begin tests_failed++; $display("FAIL areset_in_rstlow: state %0d outs %b want 4 %b", state_dbg, outs, O_RLOW); end
        #3 rst_n = 1'b0;
        dcm_locked = 1'b0;
        #1;
        tests_run++; if (outs !== O_DCM || state_dbg !== 3'd0) begin tests_failed++; $display("FAIL areset_immediate: outs %b state %0d want %b 0", outs, state_dbg, O_DCM); end
        step(1);
        rst_n = 1'b1;
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_exhaustion();
        step(72);
        tests_run++; if (outs !== O_DCM || retry_cnt !== 2'd3) begin tests_failed++; $display("FAIL exh_fourth_pulse: outs %b retry %0d want %b 3", outs, retry_cnt, O_DCM); end
        step(4);
        step(19);
        tests_run++; if (state_dbg !== 3'd1) begin tests_failed++; $display("FAIL exh_last_wait: got %0d want 1", state_dbg); end
        step(1);
        tests_run++; if (state_dbg !== 3'd7 || outs !== O_ERR || retry_cnt !== 2'd3) begin tests_failed++; $display("FAIL exh_error: state %0d outs %b retry %0d want 7 %b 3", state_dbg, outs, retry_cnt, O_ERR); end
        step(5);
        tests_run++; if (state_dbg !== 3'd7 || outs !== O_ERR) begin tests_failed++; $display("FAIL exh_error_hold: state %0d outs %b want 7 %b", state_dbg, outs, O_ERR); end
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        tests_run++; if (state_dbg !== 3'd0 || outs !== O_DCM || retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL exh_restart: state %0d outs %b retry %0d want 0 %b 0", state_dbg, outs, retry_cnt, O_DCM); end
        $display("[TB] test_exhaustion done");
    endtask

    task automatic test_restart_timeout();
        step(4);
        step(19);
        tests_run++; if (state_dbg !== 3'd1) begin tests_failed++; $display("FAIL rst_to_wait: got %0d want 1", state_dbg); end
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        tests_run++; if (state_dbg !== 3'd0 || retry_cnt !== 2'd0 || outs !== O_DCM) begin tests_failed++; $display("FAIL rst_to_restart_wins: state %0d retry %0d outs %b want 0 0 %b", state_dbg, retry_cnt, outs, O_DCM); end
        step(4);
        tests_run++; if (state_dbg !== 3'd1 || retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL rst_to_rewait: state %0d retry %0d want 1 0", state_dbg, retry_cnt); end
        $display("[TB] test_restart_timeout done");
    endtask

    // Lock first seen on the final timeout cycle must win over the timeout.
    task automatic test_lock_at_timeout();
        step(17);
        dcm_locked = 1'b1;
        step(3);
        tests_run++; if (state_dbg !== 3'd2 || retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL lock_vs_timeout: state %0d retry %0d want 2 0", state_dbg, retry_cnt); end
        $display("[TB] test_lock_at_timeout done");
    endtask

    initial begin
        rst_n      = 1'b1;
        dcm_locked = 1'b0;
        restart    = 1'b0;
        test_reset();
        test_nominal();
        test_lock_loss_ready();
        test_timeout_retry();
        test_lock_glitch();
        test_async_reset();
        test_exhaustion();
        test_restart_timeout();
        test_lock_at_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
